// File: rtl/dsp_fir_pkg.sv
// Shared types and constants for the FIR sequencer and its tap storage.
package dsp_fir_pkg;

  localparam int W_AB = 18;
  localparam int W_P  = 48;

  // DSP OPMODE encodings: P = M, and P = P + M
  localparam logic [7:0] OPM_MUL = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC = 8'b0000_1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/dsp_fir_tapline.sv
// Sample delay line and coefficient register file with one indexed read port.
module dsp_fir_tapline
  import dsp_fir_pkg::*;
#(
  parameter int TAPS = 4,
  parameter int IW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift_en,
  input  logic signed [W_AB-1:0] shift_data,
  input  logic                   coef_we,
  input  logic [IW-1:0]          coef_addr,
  input  logic signed [W_AB-1:0] coef_data,
  input  logic [IW-1:0]          rd_idx,
  output logic signed [W_AB-1:0] rd_x,
  output logic signed [W_AB-1:0] rd_h
);

  logic signed [W_AB-1:0] x_q [TAPS];
  logic signed [W_AB-1:0] h_q [TAPS];

  // Shift new samples into slot 0 and apply coefficient writes; both clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      if (shift_en) begin
        x_q[0] <= shift_data;
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
      end
      if (coef_we) h_q[coef_addr] <= coef_data;
    end
  end

  assign rd_x = x_q[rd_idx];
  assign rd_h = h_q[rd_idx];

endmodule

// File: rtl/dsp_fir_sequencer.sv
// Streams one sample per request through a TAPS-tap FIR on an external DSP slice.
//   state | meaning
//   IDLE  | waiting for a sample; coefficient writes accepted
//   ISSUE | one tap product per cycle, P = M then P = P + M
//   DRAIN | zero operands while the last products flow through the DSP pipe
//   OUT   | result held until the consumer takes it; DSP pipe frozen
module dsp_fir_sequencer
  import dsp_fir_pkg::*;
#(
  parameter int TAPS     = 4,
  parameter int DSP_LAT  = 3,
  parameter int OPM_SKEW = 1
) (
  input  logic                   clk,
  input  logic                   RSTN,
  input  logic signed [W_AB-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   coef_we,
  input  logic [3:0]             coef_addr,
  input  logic signed [W_AB-1:0] coef_data,
  output logic                   coef_err,
  output logic signed [W_AB-1:0] dsp_a,
  output logic signed [W_AB-1:0] dsp_b,
  output logic [7:0]             dsp_opmode,
  output logic                   dsp_ce,
  input  logic [W_P-1:0]         dsp_p,
  output logic [W_P-1:0]         out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int IW = $clog2(TAPS);
  localparam int DW = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;

  state_e                 state_q;
  logic [IW-1:0]          tap_q;
  logic [DW-1:0]          drain_q;
  logic                   in_ready_q, dsp_ce_q, out_valid_q, coef_err_q;
  logic [W_P-1:0]         out_data_q;

  logic                   addr_ok, coef_wr, accept;
  logic signed [W_AB-1:0] rd_x, rd_h;
  logic signed [W_AB-1:0] a_d, b_d;
  logic [7:0]             opm_d, opm_out;

  assign addr_ok = ({1'b0, coef_addr} < 5'(TAPS));
  assign coef_wr = coef_we & addr_ok & (state_q == IDLE);
  assign accept  = in_valid & in_ready_q;

  dsp_fir_tapline #(.TAPS(TAPS), .IW(IW)) u_tapline (
    .clk        (clk),
    .rst_n      (RSTN),
    .shift_en   (accept),
    .shift_data (in_data),
    .coef_we    (coef_wr),
    .coef_addr  (coef_addr[IW-1:0]),
    .coef_data  (coef_data),
    .rd_idx     (tap_q),
    .rd_x       (rd_x),
    .rd_h       (rd_h)
  );

  // Sequencing FSM with registered handshake, clock-enable and result outputs.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      drain_q     <= '0;
      in_ready_q  <= 1'b1;
      dsp_ce_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_err_q  <= 1'b0;
    end else begin
      coef_err_q <= coef_we & ~coef_wr;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= ISSUE;
            tap_q      <= '0;
            in_ready_q <= 1'b0;
            dsp_ce_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (tap_q == IW'(TAPS - 1)) begin
            state_q <= DRAIN;
            drain_q <= DW'(DSP_LAT - 1);
          end else begin
            tap_q <= tap_q + IW'(1);
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q     <= OUT;
            out_data_q  <= dsp_p;
            out_valid_q <= 1'b1;
            dsp_ce_q    <= 1'b0;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand and opmode selection for the current tap; zeros outside ISSUE.
  always_comb begin
    a_d   = '0;
    b_d   = '0;
    opm_d = 8'h00;
    if (state_q == ISSUE) begin
      a_d   = rd_x;
      b_d   = rd_h;
      opm_d = (tap_q == '0) ? OPM_MUL : OPM_ACC;
    end else if (state_q == DRAIN) begin
      opm_d = OPM_ACC;
    end
  end

  generate
    if (OPM_SKEW == 0) begin : g_no_skew
      assign opm_out = opm_d;
    end else begin : g_skew
      logic [7:0] skew_q [OPM_SKEW];
      // Delay opmode so it meets the products at the DSP P stage.
      always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
          for (int i = 0; i < OPM_SKEW; i++) skew_q[i] <= 8'h00;
        end else begin
          skew_q[0] <= opm_d;
          for (int i = 1; i < OPM_SKEW; i++) skew_q[i] <= skew_q[i-1];
        end
      end
      assign opm_out = skew_q[OPM_SKEW-1];
    end
  endgenerate

  assign in_ready   = in_ready_q;
  assign dsp_ce     = dsp_ce_q;
  assign dsp_a      = a_d;
  assign dsp_b      = b_d;
  assign dsp_opmode = opm_out;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign coef_err   = coef_err_q;

endmodule

// File: tb/tb_dsp_fir_sequencer.sv
// Closed-loop bench: sequencer plus a behavioural DSP slice, scoreboard-checked.
module tb_dsp_fir_sequencer;

  logic               clk = 1'b0;
  logic               RSTN;
  logic signed [17:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [17:0] coef_data;
  logic               coef_err;
  logic signed [17:0] dsp_a, dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_ce;
  logic [47:0]        dsp_p;
  logic [47:0]        out_data;
  logic               out_valid;
  logic               out_ready;

  always #5 clk = ~clk;

  dsp_fir_sequencer #(.TAPS(4), .DSP_LAT(3), .OPM_SKEW(1)) dut (
    .clk(clk), .RSTN(RSTN),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_p(dsp_p),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // DSP slice: A1REG/B1REG -> MREG -> PREG, OPMODEREG, all gated by CE
  logic signed [17:0] a1_r, b1_r;
  logic signed [35:0] m_r;
  logic [7:0]         opm_r;
  logic [47:0]        p_r;
  always @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      a1_r <= '0; b1_r <= '0; m_r <= '0; opm_r <= '0; p_r <= '0;
    end else if (dsp_ce) begin
      a1_r  <= dsp_a;
      b1_r  <= dsp_b;
      m_r   <= a1_r * b1_r;
      opm_r <= dsp_opmode;
      p_r   <= (opm_r[3] ? p_r : 48'd0) + (opm_r[0] ? {{12{m_r[35]}}, m_r} : 48'd0);
    end
  end
  assign dsp_p = p_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!RSTN) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_output", 64'(out_data), 64'd0);
          end else begin
            e = sb.pop_front();
            check(out_data == e.data, "out_data", 64'(out_data), 64'(e.data));
            check((cyc - e.cyc) == 8, "latency", 64'(cyc - e.cyc), 64'd8);
          end
          n_out++;
        end
        prev = out_valid;
      end
    end
  endtask

  task automatic send(input logic signed [17:0] v, input logic [47:0] e, input bit push);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check(1'b0, "in_ready_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_data  = v;
    if (push) sb.push_back('{e, cyc});
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic signed [17:0] d, input bit exp_err);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
    check(coef_err == exp_err, "coef_err", 64'(coef_err), 64'(exp_err));
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check(sb.size() == 0, "drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    int n_before;
    RSTN = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
    check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    check(dsp_ce == 1'b0, "rst_dsp_ce", 64'(dsp_ce), 64'd0);
    check(dsp_opmode == 8'h00, "rst_opmode", 64'(dsp_opmode), 64'd0);
    check(out_data == 48'd0, "rst_out_data", 64'(out_data), 64'd0);
    check(coef_err == 1'b0, "rst_coef_err", 64'(coef_err), 64'd0);
    check(dsp_a == 18'sd0 && dsp_b == 18'sd0, "rst_operands", 64'({dsp_a, dsp_b}), 64'd0);
    RSTN = 1'b1;

    // h = {1,2,3,4}
    write_coef(4'd0, 18'sd1, 1'b0);
    write_coef(4'd1, 18'sd2, 1'b0);
    write_coef(4'd2, 18'sd3, 1'b0);
    write_coef(4'd3, 18'sd4, 1'b0);

    // impulse response
    send(18'sd1, 48'd1, 1'b1);
    send(18'sd0, 48'd2, 1'b1);
    send(18'sd0, 48'd3, 1'b1);
    send(18'sd0, 48'd4, 1'b1);
    wait_drain();

    // accumulate: 10 -> 10, then 20 -> 1*20 + 2*10 = 40 under backpressure
    send(18'sd10, 48'd10, 1'b1);
    wait_drain();
    out_ready = 1'b0;
    send(18'sd20, 48'd40, 1'b1);
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check(out_valid == 1'b1, "bp_valid_timeout", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check(out_data == 48'd40, "bp_out_data", 64'(out_data), 64'd40);
      check(out_valid == 1'b1, "bp_out_valid", 64'(out_valid), 64'd1);
      check(in_ready == 1'b0, "bp_in_ready", 64'(in_ready), 64'd0);
      check(dsp_ce == 1'b0, "bp_dsp_ce", 64'(dsp_ce), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check(out_valid == 1'b0, "bp_release_valid", 64'(out_valid), 64'd0);
    check(in_ready == 1'b1, "bp_release_in_ready", 64'(in_ready), 64'd1);
    wait_drain();

    // write during ISSUE is dropped: x={0,20,10,0} -> 2*20 + 3*10 = 70
    send(18'sd0, 48'd70, 1'b1);
    coef_we = 1'b1; coef_addr = 4'd2; coef_data = 18'sd99;
    @(negedge clk);
    coef_we = 1'b0;
    check(coef_err == 1'b1, "issue_write_err", 64'(coef_err), 64'd1);
    @(negedge clk);
    check(coef_err == 1'b0, "issue_write_err_pulse", 64'(coef_err), 64'd0);
    wait_drain();

    // out-of-range address in IDLE is dropped
    write_coef(4'd5, 18'sd55, 1'b1);

    // write h0=7 together with sample 1: x={1,0,20,10} -> 7 + 3*20 + 4*10 = 107
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 18'sd7;
    in_valid = 1'b1; in_data = 18'sd1;
    sb.push_back('{48'd107, cyc});
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0; in_data = '0;
    check(coef_err == 1'b0, "same_cycle_write_err", 64'(coef_err), 64'd0);
    wait_drain();

    // reset in the middle of ISSUE aborts the sample
    send(18'sd9, 48'd0, 1'b0);
    @(negedge clk);
    RSTN = 1'b0;
    #1;
    check(in_ready == 1'b1, "abort_in_ready", 64'(in_ready), 64'd1);
    check(out_valid == 1'b0, "abort_out_valid", 64'(out_valid), 64'd0);
    check(dsp_ce == 1'b0, "abort_dsp_ce", 64'(dsp_ce), 64'd0);
    check(dsp_opmode == 8'h00, "abort_opmode", 64'(dsp_opmode), 64'd0);
    @(negedge clk);
    RSTN = 1'b1;
    n_before = n_out;
    repeat (15) @(negedge clk);
    check(n_out == n_before, "abort_no_result", 64'(n_out - n_before), 64'd0);

    // signed: h={3,0,0,0} after reset, sample -5 -> -15
    write_coef(4'd0, 18'sd3, 1'b0);
    send(-18'sd5, 48'hFFFF_FFFF_FFF1, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
